sprite_compositor: RTL and testbench

- Sits directly downstream of the game-object blocks (player, zombies, obstacles). Each object emits a 32-bit sprite entry (dina) and a slot index (addr).
- Holds an 8-slot sprite attribute table and double-buffers it per frame.
- For every pixel the VGA timing block presents, finds the highest-priority sprite covering that pixel and emits the sprite-sheet ROM address for that pixel.
- The pixel-colour lookup stage consumes its output.

---
 rtl/sprite_pkg.sv | 49 ++++
 rtl/sprite_hit_cmp.sv | 36 +++
 rtl/sprite_compositor.sv | 143 ++++++++++++++
 tb/tb_sprite_compositor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite compositor and the object blocks that build
// sprite entries: entry bit layout, sprite size defaults and ROM address packing.
package sprite_pkg;

    localparam int NUM_SLOTS_DEF = 8;
    localparam int SPR_W_DEF     = 32;
    localparam int SPR_H_DEF     = 32;

    localparam int EN_BIT   = 31;
    localparam int TAG_MSB  = 30;
    localparam int TAG_LSB  = 27;
    localparam int FLIP_BIT = 26;
    localparam int X_MSB    = 25;
    localparam int X_LSB    = 16;
    localparam int Y_MSB    = 15;
    localparam int Y_LSB    = 6;
    localparam int ROW_MSB  = 5;
    localparam int ROW_LSB  = 3;
    localparam int COL_MSB  = 2;
    localparam int COL_LSB  = 0;

    typedef struct packed {
        logic       hit;
        logic [2:0] slot;
        logic [4:0] dx;
        logic [4:0] dy;
        logic       flip;
        logic [2:0] row;
        logic [2:0] col;
    } hit_info_t;

    function automatic logic [15:0] pack_rom_addr(input logic [2:0] row,
                                                  input logic [2:0] col,
                                                  input logic [4:0] ly,
                                                  input logic [4:0] lx);
        return {row, col, ly, lx};
    endfunction

    function automatic logic [31:0] make_entry(input logic       en,
                                               input logic [3:0] tag,
                                               input logic       flip,
                                               input logic [9:0] x,
                                               input logic [9:0] y,
                                               input logic [2:0] row,
                                               input logic [2:0] col);
        return {en, tag, flip, x, y, row, col};
    endfunction

endpackage

// File: rtl/sprite_hit_cmp.sv
// Combinational coverage test of one sprite slot against the current pixel.
// Offsets are computed in 11 bits so pixels left/above the sprite never alias.
module sprite_hit_cmp
    import sprite_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF
) (
    input  logic       en,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       covers,
    output logic [4:0] dx,
    output logic [4:0] dy
);

    localparam logic [10:0] W_LIM = 11'(SPR_W);
    localparam logic [10:0] H_LIM = 11'(SPR_H);

    logic [10:0] dx_full;
    logic [10:0] dy_full;

    assign dx_full = {1'b0, pix_x} - {1'b0, sx};
    assign dy_full = {1'b0, pix_y} - {1'b0, sy};

    // Bit 10 set means the pixel lies before the sprite origin.
    assign covers = en
                  & ~dx_full[10] & (dx_full < W_LIM)
                  & ~dy_full[10] & (dy_full < H_LIM);

    assign dx = dx_full[4:0];
    assign dy = dy_full[4:0];

endmodule

// File: rtl/sprite_compositor.sv
// Double-buffered 8-slot sprite attribute table with a 2-stage per-pixel
// priority lookup producing the sprite-sheet ROM address.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int SPR_W     = SPR_W_DEF,
    parameter int SPR_H     = SPR_H_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [2:0]           addr,
    input  logic [31:0]          dina,
    input  logic                 frame_start,
    input  logic                 pix_valid,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    output logic                 out_valid,
    output logic                 hit,
    output logic [2:0]           hit_slot,
    output logic [15:0]          rom_addr,
    output logic [NUM_SLOTS-1:0] table_dirty
);

    function automatic logic [4:0] mirror_lx(input logic flip, input logic [4:0] dx);
        return flip ? (5'(SPR_W - 1) - dx) : dx;
    endfunction

    logic [31:0]          shadow [NUM_SLOTS];
    logic [31:0]          active [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] covers;
    logic [4:0]           dx_all [NUM_SLOTS];
    logic [4:0]           dy_all [NUM_SLOTS];
    hit_info_t            s1_next;
    hit_info_t            s1_p1;
    logic                 vld_p1;
    logic                 unused_tags;

    // A same-cycle write is folded into the commit so the new entry goes live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            table_dirty <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (we && addr == 3'(i)) begin
                    shadow[i] <= dina;
                end
                if (frame_start) begin
                    active[i] <= (we && addr == 3'(i)) ? dina : shadow[i];
                end
            end
            if (frame_start) begin
                table_dirty <= '0;
            end else if (we) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (addr == 3'(i)) begin
                        table_dirty[i] <= 1'b1;
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_cmp
            sprite_hit_cmp #(
                .SPR_W (SPR_W),
                .SPR_H (SPR_H)
            ) u_cmp (
                .en     (active[g][EN_BIT]),
                .sx     (active[g][X_MSB:X_LSB]),
                .sy     (active[g][Y_MSB:Y_LSB]),
                .pix_x  (pix_x),
                .pix_y  (pix_y),
                .covers (covers[g]),
                .dx     (dx_all[g]),
                .dy     (dy_all[g])
            );
        end
    endgenerate

    // Scanning downward lets the lowest covering slot overwrite all others.
    always_comb begin
        s1_next = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (covers[i]) begin
                s1_next.hit  = 1'b1;
                s1_next.slot = 3'(i);
                s1_next.dx   = dx_all[i];
                s1_next.dy   = dy_all[i];
                s1_next.flip = active[i][FLIP_BIT];
                s1_next.row  = active[i][ROW_MSB:ROW_LSB];
                s1_next.col  = active[i][COL_MSB:COL_LSB];
            end
        end
        if (!pix_valid) begin
            s1_next = '0;
        end
    end

    always_comb begin
        unused_tags = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            unused_tags = unused_tags ^ (^active[i][TAG_MSB:TAG_LSB]);
        end
    end

    // ---- stage 1: coverage / priority result ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            s1_p1  <= s1_next;
            vld_p1 <= pix_valid;
        end
    end

    // ---- stage 2: ROM address ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            hit       <= 1'b0;
            hit_slot  <= '0;
            rom_addr  <= '0;
        end else begin
            out_valid <= vld_p1;
            hit       <= s1_p1.hit;
            hit_slot  <= s1_p1.hit ? s1_p1.slot : 3'd0;
            rom_addr  <= s1_p1.hit
                       ? pack_rom_addr(s1_p1.row, s1_p1.col, s1_p1.dy,
                                       mirror_lx(s1_p1.flip, s1_p1.dx))
                       : 16'd0;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed and randomized bench for sprite_compositor, checked against an
// integer-arithmetic model of the sprite table and pixel lookup.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] dina = '0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        out_valid;
    logic        hit;
    logic [2:0]  hit_slot;
    logic [15:0] rom_addr;
    logic [7:0]  table_dirty;

    sprite_compositor dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .addr        (addr),
        .dina        (dina),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .out_valid   (out_valid),
        .hit         (hit),
        .hit_slot    (hit_slot),
        .rom_addr    (rom_addr),
        .table_dirty (table_dirty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        h;
        logic [2:0]  s;
        logic [15:0] r;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;
    logic [31:0] m_shadow [8];
    logic [31:0] m_active [8];
    logic [7:0]  m_dirty;
    exp_t        e1, e2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit en, input bit flip, input int x, input int y,
                                       input int row, input int col);
        logic [31:0] e;
        e = '0;
        e[31]    = en;
        e[30:27] = 4'($urandom_range(0, 15));
        e[26]    = flip;
        e[25:16] = 10'(x);
        e[15:6]  = 10'(y);
        e[5:3]   = 3'(row);
        e[2:0]   = 3'(col);
        return e;
    endfunction

    function automatic exp_t ref_pixel(input int px, input int py);
        exp_t r;
        int   sx, sy, lx, ly;
        r   = '0;
        r.v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sx = int'(m_active[i][25:16]);
            sy = int'(m_active[i][15:6]);
            if (!r.h && m_active[i][31] && px >= sx && px < sx + 32 && py >= sy && py < sy + 32) begin
                lx  = m_active[i][26] ? (sx + 31 - px) : (px - sx);
                ly  = py - sy;
                r.h = 1'b1;
                r.s = 3'(i);
                r.r = 16'(int'(m_active[i][5:3]) * 8192 + int'(m_active[i][2:0]) * 1024 + ly * 32 + lx);
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_dirty = '0;
        e1 = '0;
        e2 = '0;
    endtask

    // One clock of stimulus; outputs seen now belong to the pixel driven two steps ago.
    task automatic step(input bit w, input bit [2:0] a, input bit [31:0] d, input bit fs,
                        input bit pv, input bit [9:0] px, input bit [9:0] py);
        exp_t en;
        @(negedge clk);
        step_no++;
        chk("out_valid", {31'd0, out_valid}, {31'd0, e2.v});
        chk("hit", {31'd0, hit}, {31'd0, e2.h});
        chk("hit_slot", {29'd0, hit_slot}, {29'd0, e2.s});
        chk("rom_addr", {16'd0, rom_addr}, {16'd0, e2.r});
        chk("table_dirty", {24'd0, table_dirty}, {24'd0, m_dirty});
        en = pv ? ref_pixel(int'(px), int'(py)) : exp_t'(0);
        e2 = e1;
        e1 = en;
        we = w; addr = a; dina = d; frame_start = fs;
        pix_valid = pv; pix_x = px; pix_y = py;
        if (w) begin
            m_shadow[a] = d;
            m_dirty[a]  = 1'b1;
        end
        if (fs) begin
            for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
            m_dirty = '0;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int x, input int y);
        step(0, 0, 0, 0, 1, 10'(x), 10'(y));
    endtask

    task automatic wr(input int a, input logic [31:0] d, input bit fs);
        step(1, 3'(a), d, fs, 0, 0, 0);
    endtask

    task automatic commit();
        step(0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        int          s, px, py;
        bit          w, fs, pv;
        logic [31:0] d;

        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_hit_slot", {29'd0, hit_slot}, 32'd0);
        chk("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
        chk("rst_dirty", {24'd0, table_dirty}, 32'd0);
        reset = 1'b1;

        // Basic hit, bottom-right corner, one pixel past the right edge.
        wr(0, mk(1, 0, 80, 350, 0, 0), 0);
        commit();
        chk("dirty_before_commit", {24'd0, table_dirty}, 32'h01);
        pix(80, 350);
        pix(111, 381);
        pix(112, 350);
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_hit", {31'd0, hit}, 32'd1);
        chk("basic_rom", {16'd0, rom_addr}, 32'h0000);
        idle();
        chk("corner_lo10", {22'd0, rom_addr[9:0]}, 32'h3FF);
        idle();
        chk("edge_miss_hit", {31'd0, hit}, 32'd0);
        chk("edge_miss_valid", {31'd0, out_valid}, 32'd1);

        // Uncommitted write stays invisible until frame_start.
        wr(1, mk(1, 0, 400, 400, 3, 5), 0);
        pix(400, 400);
        idle();
        idle();
        chk("uncommitted_hit", {31'd0, hit}, 32'd0);
        chk("uncommitted_dirty", {24'd0, table_dirty}, 32'h02);
        commit();
        pix(400, 400);
        idle();
        idle();
        chk("committed_hit", {31'd0, hit}, 32'd1);
        chk("committed_slot", {29'd0, hit_slot}, 32'd1);
        chk("committed_rom", {16'd0, rom_addr}, 32'h7400);
        chk("committed_dirty", {24'd0, table_dirty}, 32'h00);

        // Overlap priority, then disable the winner with a same-cycle write+commit.
        wr(2, mk(1, 0, 190, 190, 1, 1), 0);
        wr(5, mk(1, 0, 195, 195, 2, 2), 1);
        pix(200, 200);
        idle();
        idle();
        chk("overlap_slot", {29'd0, hit_slot}, 32'd2);
        wr(2, 32'd0, 1);
        pix(200, 200);
        idle();
        idle();
        chk("overlap_after_disable", {29'd0, hit_slot}, 32'd5);

        // Horizontal flip.
        wr(3, mk(1, 1, 100, 600, 0, 0), 1);
        pix(100, 600);
        pix(131, 600);
        idle();
        chk("flip_left_lx", {27'd0, rom_addr[4:0]}, 32'd31);
        idle();
        chk("flip_right_lx", {27'd0, rom_addr[4:0]}, 32'd0);
        chk("flip_right_hit", {31'd0, hit}, 32'd1);

        // Clipping at the right screen edge, no wrap to x=0.
        wr(4, mk(1, 0, 1000, 700, 0, 0), 1);
        pix(1010, 700);
        pix(5, 700);
        idle();
        chk("clip_hit", {31'd0, hit}, 32'd1);
        chk("clip_lx", {27'd0, rom_addr[4:0]}, 32'd10);
        idle();
        chk("clip_nowrap", {31'd0, hit}, 32'd0);

        // Asynchronous reset mid-stream with pixels in flight.
        pix(80, 350);
        pix(80, 350);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_hit", {31'd0, hit}, 32'd0);
        chk("async_rom", {16'd0, rom_addr}, 32'd0);
        chk("async_dirty", {24'd0, table_dirty}, 32'd0);
        we = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        pix(80, 350);
        idle();
        idle();
        chk("post_reset_miss", {31'd0, hit}, 32'd0);
        wr(0, mk(1, 0, 80, 350, 0, 0), 1);
        pix(80, 350);
        idle();
        idle();
        chk("post_reset_rewrite", {31'd0, hit}, 32'd1);

        // Random writes, commits and back-to-back pixels.
        for (int n = 0; n < 800; n++) begin
            w  = ($urandom_range(0, 3) == 0);
            fs = ($urandom_range(0, 15) == 0);
            pv = ($urandom_range(0, 3) != 0);
            d  = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            s  = int'($urandom_range(0, 7));
            px = int'(m_active[s][25:16]) + int'($urandom_range(0, 40)) - 4;
            py = int'(m_active[s][15:6]) + int'($urandom_range(0, 40)) - 4;
            step(w, 3'($urandom_range(0, 7)), d, fs, pv, 10'(px), 10'(py));
        end
        idle();
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout step=%0d", step_no);
        $fatal(1, "timeout");
    end

endmodule
